// File: rtl/mac_accumulator_if.sv
// Product-in / result-out handshake bundle for mac_accumulator.
// The sat signal exists only when MAC_ACC_SAT_EN is defined.
interface mac_accumulator_if #(
    parameter int N     = 5,
    parameter int K     = 4,
    parameter int ACC_W = 12
);
    localparam int CNT_W = $clog2(K + 1);

    logic               in_valid;
    logic [2*N-1:0]     in_p;
    logic               in_ready;
    logic [ACC_W-1:0]   out_sum;
    logic               out_valid;
    logic               out_ready;
    logic               overrun;
    logic [CNT_W-1:0]   count;
`ifdef MAC_ACC_SAT_EN
    logic               sat;
`endif

    modport master (
`ifdef MAC_ACC_SAT_EN
        input  sat,
`endif
        output in_valid,
        output in_p,
        output out_ready,
        input  in_ready,
        input  out_sum,
        input  out_valid,
        input  overrun,
        input  count
    );

    modport slave (
`ifdef MAC_ACC_SAT_EN
        output sat,
`endif
        input  in_valid,
        input  in_p,
        input  out_ready,
        output in_ready,
        output out_sum,
        output out_valid,
        output overrun,
        output count
    );
endinterface

// File: rtl/mac_accumulator.sv
// Sums K multiplier products per term and hands the result out on valid/ready.
// Define MAC_ACC_SAT_EN for saturating additions and the sat output.
module mac_accumulator #(
    parameter int N     = 5,
    parameter int K     = 4,
    parameter int ACC_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    mac_accumulator_if.slave  bus
);
    localparam int P_W   = 2 * N;
    localparam int CNT_W = $clog2(K + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   sum_q;
    logic               valid_q;
    logic               overrun_q;
    logic [P_W-1:0]     prod;
    logic [ACC_W-1:0]   sum_next;

    assign prod = bus.in_p;

`ifdef MAC_ACC_SAT_EN
    // Widen past both operands so a product wider than the accumulator still clips.
    localparam int EXT_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;
    localparam logic [EXT_W-1:0] ACC_MAX = EXT_W'({ACC_W{1'b1}});

    logic [EXT_W-1:0]   sum_wide;
    logic               clip;
    logic               clip_seen;
    logic               sat_q;

    assign sum_wide = EXT_W'(acc) + EXT_W'(prod);
    assign clip     = (sum_wide > ACC_MAX);
    assign sum_next = clip ? '1 : sum_wide[ACC_W-1:0];
    assign bus.sat  = sat_q;
`else
    assign sum_next = acc + ACC_W'(prod);
`endif

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_sum   = sum_q;
    assign bus.out_valid = valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.count     = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sum_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef MAC_ACC_SAT_EN
            clip_seen <= 1'b0;
            sat_q     <= 1'b0;
`endif
        end else begin
            // The multiplier cannot stall, so a product offered during HOLD is lost.
            if (bus.in_valid && (state == HOLD)) begin
                overrun_q <= 1'b1;
            end

            case (state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        if (cnt == LAST) begin
                            sum_q   <= sum_next;
                            valid_q <= 1'b1;
                            acc     <= '0;
                            cnt     <= '0;
                            state   <= HOLD;
`ifdef MAC_ACC_SAT_EN
                            sat_q     <= clip_seen | clip;
                            clip_seen <= 1'b0;
`endif
                        end else begin
                            acc <= sum_next;
                            cnt <= cnt + CNT_W'(1);
`ifdef MAC_ACC_SAT_EN
                            clip_seen <= clip_seen | clip;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= ACCUM;
`ifdef MAC_ACC_SAT_EN
                        sat_q   <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end
endmodule
